// File: rtl/d_victim_cache_param.sv
// Fully associative, exclusive victim cache. A dirty victim is written back before it is replaced.
// Optional perf counters are enabled by defining D_VC_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | accept a lookup (has priority) or an eviction offer
// CMP    | compare tags, drive the response, invalidate the entry on a hit
// INSERT | pick a slot; write it now, or stall when the victim is dirty
// WB     | hold the dirty victim on the wb port until accepted, then write
module d_victim_cache_param #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_W      = 32,
    parameter int OFFSET_W    = 4,
    parameter int LINE_W      = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              lookup_ready_o,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic              resp_dirty_o,
    output logic [LINE_W-1:0] resp_data_o,
    input  logic              evict_valid_i,
    input  logic [ADDR_W-1:0] evict_addr_i,
    input  logic              evict_dirty_i,
    input  logic [LINE_W-1:0] evict_data_i,
    output logic              evict_ready_o,
    output logic              wb_valid_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [LINE_W-1:0] wb_data_o,
    input  logic              wb_ready_i,
    output logic [31:0]       no_acc_o,
    output logic [31:0]       no_hit_o,
    output logic [31:0]       no_miss_o
);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, CMP, INSERT, WB} state_t;
    state_t state, state_nxt;

    logic [NUM_ENTRIES-1:0] valid, dirty;
    logic [TAG_W-1:0]  tag  [NUM_ENTRIES];
    logic [LINE_W-1:0] data [NUM_ENTRIES];
    logic [IDX_W-1:0]  age  [NUM_ENTRIES];

    logic [TAG_W-1:0]  req_tag, ins_tag, wb_tag;
    logic [LINE_W-1:0] ins_data, wb_data;
    logic              ins_dirty;
    logic [IDX_W-1:0]  wb_idx;

    logic              lookup_acc, evict_acc;
    logic              hit, match, has_free, need_wb, wr_en, wr_dirty;
    logic [IDX_W-1:0]  hit_idx, match_idx, free_idx, victim_idx, ins_idx, wr_idx;
    logic [IDX_W-1:0]  victim_age;
    logic              unused_offset_bits;

    // Requests are refused while reset is held so every output reads 0.
    assign lookup_ready_o = (state == IDLE) && !rst_i;
    assign evict_ready_o  = (state == IDLE) && !lookup_valid_i && !rst_i;
    assign lookup_acc     = lookup_valid_i && lookup_ready_o;
    assign evict_acc      = evict_valid_i && evict_ready_o;
    assign unused_offset_bits = ^{lookup_addr_i[OFFSET_W-1:0], evict_addr_i[OFFSET_W-1:0]};

    // Descending scans leave the lowest matching index selected.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        match      = 1'b0;
        match_idx  = '0;
        has_free   = 1'b0;
        free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tag[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (valid[i] && (tag[i] == ins_tag)) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
        victim_idx = '0;
        victim_age = age[0];
        for (int i = 1; i < NUM_ENTRIES; i++) begin
            if (age[i] > victim_age) begin
                victim_idx = IDX_W'(i);
                victim_age = age[i];
            end
        end
    end

    assign ins_idx  = match ? match_idx : (has_free ? free_idx : victim_idx);
    assign need_wb  = !match && !has_free && dirty[victim_idx];
    assign wr_en    = ((state == INSERT) && !need_wb) || ((state == WB) && wb_ready_i);
    assign wr_idx   = (state == WB) ? wb_idx : ins_idx;
    assign wr_dirty = ins_dirty || ((state == INSERT) && match && dirty[match_idx]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (lookup_acc)     state_nxt = CMP;
                else if (evict_acc) state_nxt = INSERT;
            end
            CMP:    state_nxt = IDLE;
            INSERT: state_nxt = need_wb ? WB : IDLE;
            WB:     if (wb_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid     <= '0;
            dirty     <= '0;
            req_tag   <= '0;
            ins_tag   <= '0;
            ins_data  <= '0;
            ins_dirty <= 1'b0;
            wb_idx    <= '0;
            wb_tag    <= '0;
            wb_data   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
                age[i]  <= '0;
            end
        end else begin
            if (lookup_acc) req_tag <= lookup_addr_i[ADDR_W-1:OFFSET_W];
            if (evict_acc) begin
                ins_tag   <= evict_addr_i[ADDR_W-1:OFFSET_W];
                ins_data  <= evict_data_i;
                ins_dirty <= evict_dirty_i;
            end
            if ((state == CMP) && hit) begin
                valid[hit_idx] <= 1'b0;
                dirty[hit_idx] <= 1'b0;
            end
            if ((state == INSERT) && need_wb) begin
                wb_idx  <= victim_idx;
                wb_tag  <= tag[victim_idx];
                wb_data <= data[victim_idx];
            end
            if (wr_en) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (IDX_W'(i) == wr_idx) begin
                        valid[i] <= 1'b1;
                        dirty[i] <= wr_dirty;
                        tag[i]   <= ins_tag;
                        data[i]  <= ins_data;
                        age[i]   <= '0;
                    end else if (valid[i] && (age[i] != AGE_MAX)) begin
                        age[i] <= age[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign resp_valid_o = (state == CMP);
    assign resp_hit_o   = (state == CMP) && hit;
    assign resp_dirty_o = (state == CMP) && hit && dirty[hit_idx];
    assign resp_data_o  = ((state == CMP) && hit) ? data[hit_idx] : '0;
    assign wb_valid_o   = (state == WB);
    assign wb_addr_o    = {wb_tag, {OFFSET_W{1'b0}}};
    assign wb_data_o    = wb_data;

`ifdef D_VC_PERF_CNT_EN
    logic [31:0] cnt_acc, cnt_hit, cnt_miss;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_acc  <= '0;
            cnt_hit  <= '0;
            cnt_miss <= '0;
        end else if (state == CMP) begin
            cnt_acc <= cnt_acc + 32'd1;
            if (hit) cnt_hit  <= cnt_hit + 32'd1;
            else     cnt_miss <= cnt_miss + 32'd1;
        end
    end

    assign no_acc_o  = cnt_acc;
    assign no_hit_o  = cnt_hit;
    assign no_miss_o = cnt_miss;
`else
    assign no_acc_o  = 32'd0;
    assign no_hit_o  = 32'd0;
    assign no_miss_o = 32'd0;
`endif

endmodule

// File: tb/tb_d_victim_cache_param.sv
// Bench for d_victim_cache_param: directed vector table, hand sequences for the stall/reset corners,
// then random traffic checked against a timestamp-based reference model.
module tb_d_victim_cache_param;
    localparam int N      = 8;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int TAG_W  = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lookup_valid = 1'b0;
    logic [ADDR_W-1:0] lookup_addr = '0;
    logic              lookup_ready_o, resp_valid_o, resp_hit_o, resp_dirty_o;
    logic [LINE_W-1:0] resp_data_o;
    logic              evict_valid = 1'b0;
    logic [ADDR_W-1:0] evict_addr = '0;
    logic              evict_dirty = 1'b0;
    logic [LINE_W-1:0] evict_data = '0;
    logic              evict_ready_o, wb_valid_o;
    logic [ADDR_W-1:0] wb_addr_o;
    logic [LINE_W-1:0] wb_data_o;
    logic              wb_ready = 1'b0;
    logic [31:0]       no_acc_o, no_hit_o, no_miss_o;

    always #5 clk = ~clk;

    d_victim_cache_param dut (
        .clk_i(clk), .rst_i(rst),
        .lookup_valid_i(lookup_valid), .lookup_addr_i(lookup_addr), .lookup_ready_o(lookup_ready_o),
        .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_dirty_o(resp_dirty_o),
        .resp_data_o(resp_data_o),
        .evict_valid_i(evict_valid), .evict_addr_i(evict_addr), .evict_dirty_i(evict_dirty),
        .evict_data_i(evict_data), .evict_ready_o(evict_ready_o),
        .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_ready_i(wb_ready),
        .no_acc_o(no_acc_o), .no_hit_o(no_hit_o), .no_miss_o(no_miss_o)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] e_acc, e_hit, e_miss;

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", nm, act, exp);
        end
    endtask

    task automatic checkw(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef D_VC_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check_perf(input string nm);
        checkw({nm, ".acc"},  LINE_W'(no_acc_o),  LINE_W'(pexp(e_acc)));
        checkw({nm, ".hit"},  LINE_W'(no_hit_o),  LINE_W'(pexp(e_hit)));
        checkw({nm, ".miss"}, LINE_W'(no_miss_o), LINE_W'(pexp(e_miss)));
    endtask

    function automatic logic [LINE_W-1:0] pat(input logic [31:0] a);
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    // Reference model: an entry's age is how many writes happened since it was written, capped.
    bit                m_valid [N];
    bit                m_dirty [N];
    logic [TAG_W-1:0]  m_tag   [N];
    logic [LINE_W-1:0] m_data  [N];
    int                m_stamp [N];
    int                m_wcount;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0; m_stamp[i] = 0;
        end
        m_wcount = 0;
        e_acc = 0; e_hit = 0; e_miss = 0;
    endtask

    task automatic model_lookup(input logic [31:0] addr, output bit h, output bit d,
                                output logic [LINE_W-1:0] dat);
        h = 0; d = 0; dat = '0;
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_tag[i] == addr[31:4]) begin
                h = 1; d = m_dirty[i]; dat = m_data[i]; m_valid[i] = 0;
            end
        end
    endtask

    task automatic model_insert(input logic [31:0] addr, input bit d, input logic [LINE_W-1:0] dat,
                                output bit wb, output logic [31:0] wa, output logic [LINE_W-1:0] wd);
        int slot, best, a;
        wb = 0; wa = '0; wd = '0; slot = -1;
        for (int i = 0; i < N; i++)
            if (slot < 0 && m_valid[i] && m_tag[i] == addr[31:4]) slot = i;
        if (slot >= 0) begin
            m_dirty[slot] = m_dirty[slot] | d;
        end else begin
            for (int i = 0; i < N; i++)
                if (slot < 0 && !m_valid[i]) slot = i;
            if (slot < 0) begin
                best = -1;
                for (int i = 0; i < N; i++) begin
                    a = m_wcount - m_stamp[i] - 1;
                    if (a > N - 1) a = N - 1;
                    if (a > best) begin best = a; slot = i; end
                end
                wb = m_dirty[slot]; wa = {m_tag[slot], 4'h0}; wd = m_data[slot];
            end
            m_dirty[slot] = d;
        end
        m_valid[slot] = 1; m_tag[slot] = addr[31:4]; m_data[slot] = dat;
        m_stamp[slot] = m_wcount; m_wcount++;
    endtask

    // All driver tasks start and end on a falling edge with the DUT in IDLE.
    task automatic do_lookup(input logic [31:0] addr, input bit eh, input bit ed,
                             input logic [LINE_W-1:0] edat, input string nm);
        check1({nm, ".lk_ready"}, lookup_ready_o, 1'b1);
        lookup_valid = 1'b1; lookup_addr = addr;
        @(negedge clk);
        lookup_valid = 1'b0;
        check1({nm, ".resp_valid"}, resp_valid_o, 1'b1);
        check1({nm, ".resp_hit"}, resp_hit_o, eh);
        checkw({nm, ".resp_data"}, resp_data_o, eh ? edat : '0);
        if (eh) check1({nm, ".resp_dirty"}, resp_dirty_o, ed);
        e_acc++;
        if (eh) e_hit++; else e_miss++;
        @(negedge clk);
        check1({nm, ".resp_drop"}, resp_valid_o, 1'b0);
        check_perf(nm);
    endtask

    task automatic do_evict(input logic [31:0] addr, input bit d, input logic [LINE_W-1:0] dat,
                            input bit ewb, input logic [31:0] ewa, input logic [LINE_W-1:0] ewd,
                            input int delay, input string nm);
        check1({nm, ".ev_ready"}, evict_ready_o, 1'b1);
        evict_valid = 1'b1; evict_addr = addr; evict_dirty = d; evict_data = dat;
        @(negedge clk);
        evict_valid = 1'b0;
        check1({nm, ".wb_ins"}, wb_valid_o, 1'b0);
        @(negedge clk);
        check1({nm, ".wb_valid"}, wb_valid_o, ewb);
        if (ewb) begin
            checkw({nm, ".wb_addr"}, LINE_W'(wb_addr_o), LINE_W'(ewa));
            checkw({nm, ".wb_data"}, wb_data_o, ewd);
            for (int k = 0; k < delay; k++) begin
                @(negedge clk);
                check1({nm, ".wb_hold"}, wb_valid_o, 1'b1);
                checkw({nm, ".wb_addr_hold"}, LINE_W'(wb_addr_o), LINE_W'(ewa));
                checkw({nm, ".wb_data_hold"}, wb_data_o, ewd);
                check1({nm, ".ev_ready_stall"}, evict_ready_o, 1'b0);
                check1({nm, ".lk_ready_stall"}, lookup_ready_o, 1'b0);
            end
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            check1({nm, ".wb_drop"}, wb_valid_o, 1'b0);
            check1({nm, ".idle_after_wb"}, lookup_ready_o, 1'b1);
        end else if (wb_valid_o) begin
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
        end
    endtask

    task automatic apply_reset();
        lookup_valid = 0; evict_valid = 0; wb_ready = 0;
        lookup_addr = '0; evict_addr = '0; evict_dirty = 0; evict_data = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check1("rst.lk_ready", lookup_ready_o, 1'b0);
        check1("rst.ev_ready", evict_ready_o, 1'b0);
        check1("rst.resp_valid", resp_valid_o, 1'b0);
        checkw("rst.resp_data", resp_data_o, '0);
        check1("rst.wb_valid", wb_valid_o, 1'b0);
        checkw("rst.wb_addr", LINE_W'(wb_addr_o), '0);
        checkw("rst.wb_data", wb_data_o, '0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check1("post_rst.lk_ready", lookup_ready_o, 1'b1);
        check1("post_rst.ev_ready", evict_ready_o, 1'b1);
        check_perf("post_rst");
    endtask

    task automatic fill8(input bit first_dirty);
        bit w; logic [31:0] wa; logic [LINE_W-1:0] wd;
        for (int i = 0; i < N; i++) begin
            model_insert(32'(i * 16), first_dirty && i == 0, pat(32'(i * 16)), w, wa, wd);
            do_evict(32'(i * 16), first_dirty && i == 0, pat(32'(i * 16)), w, wa, wd, 0, "fill");
        end
    endtask

    typedef struct {
        bit                is_evict;
        logic [31:0]       addr;
        bit                dirty;
        logic [LINE_W-1:0] data;
        bit                exp_hit;
        bit                exp_dirty;
        logic [LINE_W-1:0] exp_data;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [17];
        logic [LINE_W-1:0] a5;
        bit h, d, w, dty;
        logic [31:0] wa, addr, tg;
        logic [LINE_W-1:0] dat, wd;

        a5 = {16{8'hA5}};
        tbl[0] = '{0, 32'h1000, 0, '0, 0, 0, '0};
        tbl[1] = '{1, 32'h2000, 0, a5, 0, 0, '0};
        tbl[2] = '{0, 32'h2008, 0, '0, 1, 0, a5};
        tbl[3] = '{0, 32'h2000, 0, '0, 0, 0, '0};
        for (int i = 0; i < 8; i++)
            tbl[4 + i] = '{1, 32'(i * 16), 0, pat(32'(i * 16)), 0, 0, '0};
        tbl[12] = '{1, 32'h80, 0, pat(32'h80), 0, 0, '0};
        tbl[13] = '{0, 32'h0,  0, '0, 0, 0, '0};
        tbl[14] = '{0, 32'h80, 0, '0, 1, 0, pat(32'h80)};
        tbl[15] = '{0, 32'h44, 0, '0, 1, 0, pat(32'h40)};
        tbl[16] = '{0, 32'h44, 0, '0, 0, 0, '0};

        apply_reset();
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].is_evict)
                do_evict(tbl[i].addr, tbl[i].dirty, tbl[i].data, 0, '0, '0, 0, $sformatf("vec%0d", i));
            else
                do_lookup(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_dirty, tbl[i].exp_data,
                          $sformatf("vec%0d", i));
        end

        // Simultaneous lookup and eviction offer, then dirty merge on a repeated tag.
        apply_reset();
        model_insert(32'h10, 0, pat(32'h10), w, wa, wd);
        do_evict(32'h10, 0, pat(32'h10), 0, '0, '0, 0, "sc_a");
        model_insert(32'h30, 0, pat(32'h30), w, wa, wd);
        do_evict(32'h30, 0, pat(32'h30), 0, '0, '0, 0, "sc_b");
        lookup_valid = 1; lookup_addr = 32'h18;
        evict_valid = 1; evict_addr = 32'h20; evict_dirty = 1; evict_data = pat(32'h20);
        #1;
        check1("sc.ev_ready_blocked", evict_ready_o, 1'b0);
        check1("sc.lk_ready", lookup_ready_o, 1'b1);
        @(negedge clk);
        lookup_valid = 0;
        check1("sc.resp_valid", resp_valid_o, 1'b1);
        check1("sc.resp_hit", resp_hit_o, 1'b1);
        checkw("sc.resp_data", resp_data_o, pat(32'h10));
        check1("sc.ev_ready_cmp", evict_ready_o, 1'b0);
        @(negedge clk);
        check1("sc.ev_ready_idle", evict_ready_o, 1'b1);
        @(negedge clk);
        evict_valid = 0;
        check1("sc.insert_busy", lookup_ready_o, 1'b0);
        @(negedge clk);
        check1("sc.back_idle", lookup_ready_o, 1'b1);
        model_lookup(32'h10, h, d, dat);
        model_insert(32'h20, 1, pat(32'h20), w, wa, wd);
        e_acc++; e_hit++;
        model_lookup(32'h20, h, d, dat);
        do_lookup(32'h20, 1, 1, pat(32'h20), "sc_lk20");
        model_insert(32'h30, 1, pat(32'h33), w, wa, wd);
        do_evict(32'h30, 1, pat(32'h33), 0, '0, '0, 0, "dup_a");
        model_insert(32'h30, 0, pat(32'h34), w, wa, wd);
        do_evict(32'h30, 0, pat(32'h34), 0, '0, '0, 0, "dup_b");
        model_lookup(32'h30, h, d, dat);
        do_lookup(32'h30, 1, 1, pat(32'h34), "dup_hit");
        model_lookup(32'h30, h, d, dat);
        do_lookup(32'h30, 0, 0, '0, "dup_gone");

        // Dirty victim with a five-cycle writeback stall.
        apply_reset();
        fill8(1);
        model_insert(32'h90, 0, pat(32'h90), w, wa, wd);
        do_evict(32'h90, 0, pat(32'h90), 1, 32'h0, pat(32'h0), 5, "wb");
        model_lookup(32'h90, h, d, dat);
        do_lookup(32'h90, 1, 0, pat(32'h90), "wb_new");
        model_lookup(32'h0, h, d, dat);
        do_lookup(32'h0, 0, 0, '0, "wb_old");
        do_lookup(32'h10, 1, 0, pat(32'h10), "wb_kept");

        // Reset while a writeback is pending.
        apply_reset();
        fill8(1);
        evict_valid = 1; evict_addr = 32'hA0; evict_dirty = 0; evict_data = pat(32'hA0);
        @(negedge clk);
        evict_valid = 0;
        @(negedge clk);
        check1("rwb.wb_valid", wb_valid_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check1("rwb.wb_valid0", wb_valid_o, 1'b0);
        checkw("rwb.wb_addr0", LINE_W'(wb_addr_o), '0);
        checkw("rwb.wb_data0", wb_data_o, '0);
        check1("rwb.lk_ready0", lookup_ready_o, 1'b0);
        check1("rwb.ev_ready0", evict_ready_o, 1'b0);
        check1("rwb.resp_valid0", resp_valid_o, 1'b0);
        model_reset();
        check_perf("rwb");
        rst = 1'b0;
        @(negedge clk);
        do_lookup(32'h0,  0, 0, '0, "rwb_lk0");
        do_lookup(32'h10, 0, 0, '0, "rwb_lk10");
        do_lookup(32'hA0, 0, 0, '0, "rwb_lkA0");

        // Random traffic against the reference model.
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            tg = 32'($urandom_range(0, 11));
            addr = 32'h0004_0000 | (tg << 4) | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                model_lookup(addr, h, d, dat);
                do_lookup(addr, h, d, dat, "rnd_lk");
            end else begin
                dty = 1'($urandom_range(0, 1));
                dat = {$urandom, $urandom, $urandom, $urandom};
                model_insert(addr, dty, dat, w, wa, wd);
                do_evict(addr, dty, dat, w, wa, wd, int'($urandom_range(0, 3)), "rnd_ev");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
